bcd_to_bin_seq: RTL and testbench

//  Sequential decoder from multi-digit BCD (sign-magnitude) to two's-complement binary.
//  It sits downstream of the BCD adder/subtractor datapath and hands decimal results to

---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_mac10.sv | 25 ++
 rtl/bcd_to_bin_seq.sv | 136 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary decoder: digit geometry,
// FSM state encoding and the width rule that ties digit count to magnitude width.
package bcd_pkg;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] BCD_MAX     = 4'd9;

   // Encoding 2'd3 is unused and steers the FSM back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_FIN  = 2'd2
   } bcd_state_t;

   // Smallest magnitude width w with 2**w > 10**digits-1.
   function automatic int bcd_bin_width(input int digits);
      longint max_val;
      int     width;
      max_val = 64'sd1;
      for (int i = 0; i < digits; i++) begin
         max_val = max_val * 64'sd10;
      end
      max_val = max_val - 64'sd1;
      width   = 1;
      for (int w = 1; w < 63; w++) begin
         if ((64'sd1 <<< w) > max_val) begin
            width = w;
            break;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational decimal multiply-accumulate step: acc*10 + digit,
// with a flag for a digit outside the legal 0..9 range.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic [BIN_W-1:0]       i_acc,
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BIN_W-1:0]       o_acc_next,
   output logic                   o_digit_err
);

   logic [BIN_W-1:0] w_acc_x10;
   logic [BIN_W-1:0] w_digit_ext;

   // acc*10 built as (acc<<3)+(acc<<1); the sum is allowed to wrap at BIN_W bits.
   always_comb begin
      w_acc_x10   = (i_acc << 3) + (i_acc << 1);
      w_digit_ext = {{(BIN_W-BCD_DIGIT_W){1'b0}}, i_digit};
      o_acc_next  = w_acc_x10 + w_digit_ext;
      o_digit_err = (i_digit > BCD_MAX);
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential sign-magnitude BCD to two's-complement decoder.
// One digit per clock, most-significant digit first, start/ready/done handshake.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
   input  logic                      neg_in,
   output logic                      ready,
   output logic                      done,
   output logic [BIN_W:0]            bin_out,
   output logic                      err
);

   localparam int SHIFT_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

   // Reject a magnitude width that cannot hold 10**DIGITS-1.
   if (BIN_W < bcd_bin_width(DIGITS)) begin : g_bad_width
      $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
   end

   bcd_state_t           r_state;
   logic [SHIFT_W-1:0]   r_shift;
   logic                 r_neg;
   logic [BIN_W-1:0]     r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_err_s;
   logic                 r_ready;
   logic                 r_done;
   logic [BIN_W:0]       r_bin;
   logic                 r_err;

   logic [BCD_DIGIT_W-1:0] w_digit;
   logic [BIN_W-1:0]       w_acc_next;
   logic                   w_digit_err;
   logic                   w_err_next;
   logic [BIN_W:0]         w_mag;
   logic [BIN_W:0]         w_result;

   assign w_digit = r_shift[SHIFT_W-1 -: BCD_DIGIT_W];

   bcd_mac10 #(
      .BIN_W (BIN_W)
   ) u_mac10 (
      .i_acc       (r_acc),
      .i_digit     (w_digit),
      .o_acc_next  (w_acc_next),
      .o_digit_err (w_digit_err)
   );

   // Final signed result from the last accumulate step; errors force zero.
   always_comb begin
      w_err_next = r_err_s | w_digit_err;
      w_mag      = {1'b0, w_acc_next};
      w_result   = {(BIN_W+1){1'b0}};
      if (w_err_next) begin
         w_result = {(BIN_W+1){1'b0}};
      end else if (r_neg) begin
         w_result = {(BIN_W+1){1'b0}} - w_mag;
      end else begin
         w_result = w_mag;
      end
   end

   // Control FSM with digit counter, shift register and registered handshake outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_shift <= {SHIFT_W{1'b0}};
         r_neg   <= 1'b0;
         r_acc   <= {BIN_W{1'b0}};
         r_cnt   <= {CNT_W{1'b0}};
         r_err_s <= 1'b0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_bin   <= {(BIN_W+1){1'b0}};
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_shift <= bcd_in;
                  r_neg   <= neg_in;
                  r_acc   <= {BIN_W{1'b0}};
                  r_cnt   <= CNT_LAST;
                  r_err_s <= 1'b0;
                  r_ready <= 1'b0;
                  r_state <= ST_CONV;
               end else begin
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_CONV: begin
               r_acc   <= w_acc_next;
               r_shift <= r_shift << BCD_DIGIT_W;
               r_err_s <= w_err_next;
               if (r_cnt == {CNT_W{1'b0}}) begin
                  // Outputs are loaded here so they are valid during FIN.
                  r_bin   <= w_result;
                  r_err   <= w_err_next;
                  r_done  <= 1'b1;
                  r_state <= ST_FIN;
               end else begin
                  r_cnt   <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                  r_state <= ST_CONV;
               end
            end
            ST_FIN: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready   = r_ready;
   assign done    = r_done;
   assign bin_out = r_bin;
   assign err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (DIGITS=4, BIN_W=14) with a result scoreboard.
module tb_bcd_to_bin_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] bcd_in = 16'h0000;
   logic        neg_in = 1'b0;
   logic        ready;
   logic        done;
   logic [14:0] bin_out;
   logic        err;

   int total = 0;
   int bad   = 0;
   logic [15:0] sb_q[$];

   bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .neg_in  (neg_in),
      .ready   (ready),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode: {err, bin[14:0]}.
   function automatic logic [15:0] model(input logic [15:0] bcd, input logic neg);
      int         val;
      logic       e;
      logic [3:0] d;
      logic [14:0] b;
      val = 0;
      e   = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         d = bcd[4*i +: 4];
         if (d > 4'd9) e = 1'b1;
         val = val * 10 + int'(d);
      end
      if (e) b = 15'd0;
      else if (neg) b = 15'(-val);
      else b = 15'(val);
      return {e, b};
   endfunction

   // One conversion; optional stray start with another operand in cycle 2.
   task automatic convert(input string tag, input logic [15:0] bcd, input logic neg,
                          input logic glitch, input logic [15:0] gbcd);
      int          pulses;
      int          done_cyc;
      logic [15:0] exp;
      pulses   = 0;
      done_cyc = 0;
      @(negedge clock);
      start  = 1'b1;
      bcd_in = bcd;
      neg_in = neg;
      sb_q.push_back(model(bcd, neg));
      @(posedge clock);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (k == 1) begin
            start  = 1'b0;
            bcd_in = 16'hFFFF;
            neg_in = ~neg;
         end
         if (k == 2 && glitch) begin
            start  = 1'b1;
            bcd_in = gbcd;
         end
         if (k == 3) start = 1'b0;
         if (k == 5) chk({tag, "_ready_in_fin"}, {31'd0, ready}, 32'd0);
         if (k == 6) chk({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
         if (done === 1'b1) begin
            pulses++;
            if (done_cyc == 0) done_cyc = k;
            if (sb_q.size() > 0) begin
               exp = sb_q.pop_front();
               chk({tag, "_bin"}, {17'd0, bin_out}, {17'd0, exp[14:0]});
               chk({tag, "_err"}, {31'd0, err}, {31'd0, exp[15]});
            end
         end
      end
      chk({tag, "_done_pulses"}, pulses, 32'd1);
      chk({tag, "_done_cycle"}, done_cyc, 32'd5);
      chk({tag, "_sb_empty"}, sb_q.size(), 32'd0);
      sb_q.delete();
   endtask

   initial begin : main
      int aborted_done;
      // 1. reset
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_bin", {17'd0, bin_out}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);

      // 2-4. main function, signs, negative zero, illegal digit recovery
      convert("pos9999", 16'h9999, 1'b0, 1'b0, 16'h0000);
      chk("pos9999_const", {17'd0, bin_out}, 32'h270F);
      convert("neg42", 16'h0042, 1'b1, 1'b0, 16'h0000);
      chk("neg42_const", {17'd0, bin_out}, 32'h7FD6);
      convert("negzero", 16'h0000, 1'b1, 1'b0, 16'h0000);
      convert("neg9999", 16'h9999, 1'b1, 1'b0, 16'h0000);
      convert("illegal", 16'h12A4, 1'b0, 1'b0, 16'h0000);
      chk("illegal_err_const", {31'd0, err}, 32'd1);
      convert("after_err", 16'h0001, 1'b0, 1'b0, 16'h0000);
      convert("illegal_top", 16'hF000, 1'b1, 1'b0, 16'h0000);
      convert("mixed", 16'h0807, 1'b0, 1'b0, 16'h0000);

      // 5. start during CONV is ignored
      convert("ignore_start", 16'h1234, 1'b0, 1'b1, 16'h5678);
      chk("ignore_start_const", {17'd0, bin_out}, 32'h04D2);

      // 6. reset mid-conversion aborts
      aborted_done = 0;
      @(negedge clock);
      start  = 1'b1;
      bcd_in = 16'h0500;
      neg_in = 1'b0;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_bin", {17'd0, bin_out}, 32'd0);
      chk("abort_err", {31'd0, err}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         if (done === 1'b1) aborted_done++;
         @(negedge clock);
      end
      chk("abort_no_done", aborted_done, 32'd0);

      convert("post_abort", 16'h0007, 1'b1, 1'b0, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
